alu_seq: RTL and testbench

Multi-cycle instruction sequencer that drives the combinational ALU from the opposite side of its control interface. Accepts one packed instruction per valid/ready handshake, presents op_code, source selects and immediates to the ALU, captures alu_out and the carry/borrow outputs, and retires the result to the register file or word memory. Sits between instruction fetch and the ALU/register-file datapath.

---
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: issue -> capture -> retire, 1 instruction per 4 cycles.
// Optional carry/borrow chaining is compiled in with `define ALU_SEQ_FLAGS_EN.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int IWIDTH  = 8,
    parameter int SOURCES = 4,
    localparam int SW      = $clog2(SOURCES),
    localparam int INSTR_W = IWIDTH + 2*SW + WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [IWIDTH-1:0]  op_code,
    output logic [SW-1:0]      source1_choice,
    output logic [SW-1:0]      source2_choice,
    output logic [WIDTH-1:0]   imm_a,
    output logic [WIDTH-1:0]   imm_b,
    output logic               alu_c_in,
    output logic               alu_b_in,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_c_out,
    input  logic               alu_b_out,
    output logic               rf_we,
    output logic               mem_we,
    output logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   acc,
    output logic               done,
    output logic               illegal
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RETIRE  = 2'd3
    } state_t;

    localparam logic [IWIDTH-1:0] OP_ADD = IWIDTH'(8'h07);
    localparam logic [IWIDTH-1:0] OP_SUB = IWIDTH'(8'h08);
    localparam logic [IWIDTH-1:0] OP_ST  = IWIDTH'(8'h1D);
    localparam logic [IWIDTH-1:0] OP_STN = IWIDTH'(8'h1E);

    state_t             state_q;
    state_t             state_nxt;
    logic [IWIDTH-1:0]  ir_op_q;
    logic [SW-1:0]      ir_src1_q;
    logic [SW-1:0]      ir_src2_q;
    logic [WIDTH-1:0]   ir_imm_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   acc_q;
    logic               accept;
    logic               op_is_mem;
    logic               op_is_rf;

    assign accept = instr_valid && instr_ready;

    // Opcode decode of the held instruction; anything not listed retires as illegal.
    always_comb begin
        op_is_mem = (ir_op_q == OP_ST) || (ir_op_q == OP_STN);
        op_is_rf  = (ir_op_q <= IWIDTH'(8'h11))
                 || (ir_op_q == IWIDTH'(8'h1B))
                 || (ir_op_q == IWIDTH'(8'h1C))
                 || (ir_op_q == IWIDTH'(8'h1F))
                 || (ir_op_q == IWIDTH'(8'h20))
                 || (ir_op_q == IWIDTH'(8'h21));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_RETIRE;
            S_RETIRE:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        rf_we       = 1'b0;
        mem_we      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_IDLE: instr_ready = 1'b1;
            S_RETIRE: begin
                done    = 1'b1;
                mem_we  = op_is_mem;
                rf_we   = op_is_rf;
                illegal = !op_is_mem && !op_is_rf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_op_q   <= '0;
            ir_src1_q <= '0;
            ir_src2_q <= '0;
            ir_imm_q  <= '0;
        end else if (accept) begin
            ir_op_q   <= instr[INSTR_W-1 -: IWIDTH];
            ir_src1_q <= instr[WIDTH+SW +: SW];
            ir_src2_q <= instr[WIDTH +: SW];
            ir_imm_q  <= instr[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (state_q == S_CAPTURE) begin
            result_q <= alu_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == S_RETIRE && op_is_rf) begin
            acc_q <= result_q;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic c_flag_q;
    logic b_flag_q;

    // Flags are sampled with the result so the next ADD/SUB chains on them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_flag_q <= 1'b0;
            b_flag_q <= 1'b0;
        end else if (state_q == S_CAPTURE) begin
            if (ir_op_q == OP_ADD) c_flag_q <= alu_c_out;
            if (ir_op_q == OP_SUB) b_flag_q <= alu_b_out;
        end
    end

    assign alu_c_in = c_flag_q;
    assign alu_b_in = b_flag_q;
`else
    logic unused_flags;
    assign unused_flags = alu_c_out ^ alu_b_out;
    assign alu_c_in     = 1'b0;
    assign alu_b_in     = 1'b0;
`endif

    assign op_code        = ir_op_q;
    assign source1_choice = ir_src1_q;
    assign source2_choice = ir_src2_q;
    assign imm_a          = ir_imm_q;
    assign imm_b          = ir_imm_q;
    assign wdata          = result_q;
    assign acc            = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded random bench for alu_seq with a behavioural ALU and sequencer model.
module tb_alu_seq;
    localparam int WIDTH = 8, IWIDTH = 8, SOURCES = 4, SW = 2;
    localparam int INSTR_W = IWIDTH + 2*SW + WIDTH;

    logic clk = 1'b0, rst = 1'b1;
    logic instr_valid = 1'b0;
    logic [INSTR_W-1:0] instr = '0;
    logic instr_ready, alu_c_in, alu_b_in, alu_c_out, alu_b_out;
    logic rf_we, mem_we, done, illegal;
    logic [IWIDTH-1:0] op_code;
    logic [SW-1:0] source1_choice, source2_choice;
    logic [WIDTH-1:0] imm_a, imm_b, alu_out, wdata, acc;

    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0] wdata;
        int         kind;      // 0 register write, 1 memory write, 2 illegal
        logic [7:0] acc_before;
        logic [7:0] acc_after;
        logic       cf;
        logic       bf;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_acc = 8'h00;
    logic       m_c = 1'b0, m_b = 1'b0;
    logic       hold_mode = 1'b0;

    alu_seq #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .SOURCES(SOURCES)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .op_code(op_code),
        .source1_choice(source1_choice), .source2_choice(source2_choice),
        .imm_a(imm_a), .imm_b(imm_b), .alu_c_in(alu_c_in), .alu_b_in(alu_b_in),
        .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_b_out(alu_b_out),
        .rf_we(rf_we), .mem_we(mem_we), .wdata(wdata), .acc(acc),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Environment ALU: source 0 is the immediate, sources 1..3 are fixed register values.
    function automatic logic [7:0] src_val(input logic [1:0] sel, input logic [7:0] imm);
        case (sel)
            2'd0: return imm;
            2'd1: return 8'hFF;
            2'd2: return 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [9:0] alu_fn(input logic [7:0] op, input logic [1:0] s1,
                                          input logic [1:0] s2, input logic [7:0] imm,
                                          input logic cin, input logic bin);
        int a, b, r;
        a = int'(src_val(s1, imm));
        b = int'(src_val(s2, imm));
        if (op == 8'h07) begin
            r = a + b + int'(cin);
            return {1'b0, r >= 256, 8'(r % 256)};
        end else if (op == 8'h08) begin
            r = a - b - int'(bin);
            return {r < 0, 1'b0, 8'((r + 512) % 256)};
        end
        return {2'b00, 8'(a ^ b)};
    endfunction

    always_comb {alu_b_out, alu_c_out, alu_out} =
        alu_fn(op_code, source1_choice, source2_choice, imm_a, alu_c_in, alu_b_in);

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Expected outcome of one accepted instruction, built from the opcode table.
    task automatic model_push(input logic [7:0] op, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [7:0] imm);
        exp_t e;
        logic [9:0] r;
        r = alu_fn(op, s1, s2, imm, m_c, m_b);
`ifdef ALU_SEQ_FLAGS_EN
        if (op == 8'h07) m_c = r[8];
        if (op == 8'h08) m_b = r[9];
`endif
        e.wdata = r[7:0];
        e.acc_before = m_acc;
        if (op == 8'h1D || op == 8'h1E) e.kind = 1;
        else if (op <= 8'h11 || op == 8'h1B || op == 8'h1C || op == 8'h1F
                 || op == 8'h20 || op == 8'h21) e.kind = 0;
        else e.kind = 2;
        if (e.kind == 0) m_acc = r[7:0];
        e.acc_after = m_acc;
        e.cf = m_c;
        e.bf = m_b;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [7:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [7:0] imm, input int gap);
        int waited = 0;
        instr = {op, s1, s2, imm};
        instr_valid = 1'b1;
        while (!instr_ready) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 20) begin
                $display("FAIL accept_timeout actual=%0d required<=20", waited);
                errors++;
                checks++;
                instr_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_push(op, s1, s2, imm);
        #1;
        if (!hold_mode) begin
            instr_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic check_reset_values();
        chk("rst_ready", int'(instr_ready), 1);
        chk("rst_op", int'(op_code), 0);
        chk("rst_sel", int'({source1_choice, source2_choice}), 0);
        chk("rst_imm", int'({imm_a, imm_b}), 0);
        chk("rst_cin", int'(alu_c_in), 0);
        chk("rst_bin", int'(alu_b_in), 0);
        chk("rst_strobes", int'({rf_we, mem_we}), 0);
        chk("rst_done", int'({done, illegal}), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_acc", int'(acc), 0);
    endtask

    // Monitor: pops one expectation per done pulse, checks acc the cycle after.
    int cyc = 0, last_acc_cyc = -1, last_done_cyc = -1;
    logic acc_pend = 1'b0;
    logic [7:0] acc_pend_val;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            acc_pend = 1'b0;
            last_acc_cyc = -1;
            last_done_cyc = -1;
        end else begin
            if (acc_pend) begin
                chk("acc_after", int'(acc), int'(acc_pend_val));
                acc_pend = 1'b0;
            end
            if (!hold_mode) begin
                last_acc_cyc = -1;
                last_done_cyc = -1;
            end
            if (instr_valid && instr_ready) begin
                if (hold_mode && last_acc_cyc >= 0) chk("accept_gap", cyc - last_acc_cyc, 4);
                last_acc_cyc = cyc;
            end
            if (done) begin
                if (hold_mode && last_done_cyc >= 0) chk("done_gap", cyc - last_done_cyc, 4);
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_done actual=1 required=0");
                    errors++;
                    checks++;
                end else begin
                    e = sb.pop_front();
                    chk("wdata", int'(wdata), int'(e.wdata));
                    chk("rf_we", int'(rf_we), int'(e.kind == 0));
                    chk("mem_we", int'(mem_we), int'(e.kind == 1));
                    chk("illegal", int'(illegal), int'(e.kind == 2));
                    chk("acc_at_retire", int'(acc), int'(e.acc_before));
                    chk("carry_flag", int'(alu_c_in), int'(e.cf));
                    chk("borrow_flag", int'(alu_b_in), int'(e.bf));
                    acc_pend = 1'b1;
                    acc_pend_val = e.acc_after;
                end
            end else if (rf_we || mem_we || illegal) begin
                $display("FAIL strobe_without_done actual=%0b required=000",
                         {rf_we, mem_we, illegal});
                errors++;
                checks++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rand_op();
        logic [7:0] ok_list [5];
        ok_list = '{8'h1B, 8'h1C, 8'h1F, 8'h20, 8'h21};
        case ($urandom_range(0, 7))
            0, 7: return 8'h07;
            1: return 8'h08;
            2: return ($urandom_range(0, 1) != 0) ? 8'h1D : 8'h1E;
            3: return 8'($urandom_range(0, 17));
            4: return ok_list[$urandom_range(0, 4)];
            5: return 8'($urandom_range(18, 26));
            default: return 8'($urandom_range(34, 255));
        endcase
    endfunction

    initial begin
        int w;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of CAPTURE of an ADD that would set carry.
        issue(8'h07, 2'd0, 2'd1, 8'hFF, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_values();
        sb.delete();
        m_acc = 8'h00; m_c = 1'b0; m_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values();

        // Directed chain: carry-producing ADD, chained ADD, SUB borrow, ST, illegal.
        issue(8'h07, 2'd0, 2'd1, 8'hFF, 0);
        issue(8'h07, 2'd0, 2'd2, 8'h03, 1);
        issue(8'h08, 2'd0, 2'd3, 8'h00, 0);
        issue(8'h1D, 2'd0, 2'd2, 8'h5A, 2);
        issue(8'h30, 2'd0, 2'd0, 8'h11, 0);

        // Valid held continuously: accepts and retires must be exactly 4 cycles apart.
        hold_mode = 1'b1;
        for (int i = 0; i < 6; i++)
            issue((i % 2 == 0) ? 8'h30 : 8'h07, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom), 0);
        hold_mode = 1'b0;
        instr_valid = 1'b0;

        for (int i = 0; i < 60; i++)
            issue(rand_op(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  8'($urandom), $urandom_range(0, 3));

        w = 0;
        while (sb.size() != 0 && w < 50) begin @(posedge clk); #1; w++; end
        if (sb.size() != 0) chk("drain", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
